// File: rtl/keycode_report_packer_if.sv
// keycode_report_packer_if: byte-stream input and keycode output bundle between host and packer
interface keycode_report_packer_if;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_sof;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        report_error;
  modport master (
    output byte_valid, byte_data, byte_sof,
    input  byte_ready, keycode, keycode_valid, report_error
  );
  modport slave (
    input  byte_valid, byte_data, byte_sof,
    output byte_ready, keycode, keycode_valid, report_error
  );
endinterface

// File: rtl/keycode_report_packer.sv
// keycode_report_packer: packs up to two HID boot-report key codes into one 16-bit word (ports: Clk, Reset, bus.slave byte stream in / keycode out)
module keycode_report_packer #(
  parameter int          REPORT_BYTES  = 8,
  parameter logic [7:0]  ROLLOVER_CODE = 8'h01
) (
  input logic                    Clk,
  input logic                    Reset,
  keycode_report_packer_if.slave bus
);
  localparam int IW = $clog2(REPORT_BYTES);
  localparam logic [IW-1:0] LAST = IW'(REPORT_BYTES - 1);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, COMMIT = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    slot0_q, slot0_d, slot1_q, slot1_d;
  logic          roll_q, roll_d;
  logic [15:0]   keycode_q, keycode_d;
  logic          kv_q, kv_d, err_q, err_d;
  logic          accept, key_byte;
  assign bus.byte_ready    = state_q != COMMIT;
  assign bus.keycode       = keycode_q;
  assign bus.keycode_valid = kv_q;
  assign bus.report_error  = err_q;
  assign accept   = bus.byte_valid && bus.byte_ready;
  // key slots start at byte 2; zero bytes mean "no key" and never occupy a slot
  assign key_byte = idx_q >= IW'(2) && bus.byte_data != 8'h00;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    roll_d    = roll_q;
    keycode_d = keycode_q;
    kv_d      = 1'b0;
    err_d     = 1'b0;
    if (state_q == COMMIT) begin
      kv_d      = !roll_q;
      err_d     = roll_q;
      keycode_d = roll_q ? keycode_q : {slot0_q, slot1_q};
      state_d   = IDLE;
    end else if (accept && bus.byte_sof) begin
      // a start-of-frame while collecting abandons the partial report
      err_d   = state_q == COLLECT;
      idx_d   = IW'(1);
      slot0_d = 8'h00;
      slot1_d = 8'h00;
      roll_d  = 1'b0;
      state_d = COLLECT;
    end else if (accept && state_q == IDLE) begin
      err_d = 1'b1;
    end else if (accept) begin
      idx_d   = idx_q + IW'(1);
      state_d = idx_q == LAST ? COMMIT : COLLECT;
      if (key_byte && bus.byte_data == ROLLOVER_CODE) roll_d = 1'b1;
      else if (key_byte && slot0_q == 8'h00) slot0_d = bus.byte_data;
      else if (key_byte && slot1_q == 8'h00 && bus.byte_data != slot0_q) slot1_d = bus.byte_data;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      slot0_q   <= 8'h00;
      slot1_q   <= 8'h00;
      roll_q    <= 1'b0;
      keycode_q <= 16'h0000;
      kv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      roll_q    <= roll_d;
      keycode_q <= keycode_d;
      kv_q      <= kv_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_keycode_report_packer.sv
// tb_keycode_report_packer: table-driven and directed checks of the keycode report packer
module tb_keycode_report_packer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0, failures = 0;
  int kv_cnt = 0, err_cnt = 0;
  keycode_report_packer_if bus();
  keycode_report_packer dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (bus.keycode_valid) kv_cnt++;
    if (bus.report_error) err_cnt++;
  end
  typedef struct packed {
    logic [63:0] rep;
    bit          gaps;
    logic [15:0] k;
    bit          v;
    bit          e;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit s);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_sof   = s;
    while (!bus.byte_ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (t == 20) chk("ready_timeout", 0, 1);
    @(negedge Clk);
    bus.byte_valid = 1'b0;
    bus.byte_sof   = 1'b0;
  endtask
  task automatic send_bytes(input logic [63:0] r, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge Clk);
      send(r[63-8*i -: 8], i == 0);
    end
  endtask
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_sof   = 1'b0;
    vecs[0] = '{64'h0000_1A52_0000_0000, 1'b0, 16'h1A52, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0101_0101_0101, 1'b0, 16'h1A52, 1'b0, 1'b1};
    vecs[2] = '{64'h0200_0004_072C_0000, 1'b1, 16'h0407, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0505_0506_0000, 1'b0, 16'h0506, 1'b1, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_0009, 1'b1, 16'h0900, 1'b1, 1'b0};
    vecs[5] = '{64'h0000_0401_0000_0000, 1'b0, 16'h0900, 1'b0, 1'b1};
    vecs[6] = '{64'h0033_0800_0000_0000, 1'b1, 16'h0800, 1'b1, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_keycode", 32'(bus.keycode), 32'h0000);
    chk("reset_kv", 32'(bus.keycode_valid), 0);
    chk("reset_err", 32'(bus.report_error), 0);
    chk("reset_ready", 32'(bus.byte_ready), 1);
    for (int i = 0; i < 8; i++) begin
      send_bytes(vecs[i].rep, 8, vecs[i].gaps);
      chk($sformatf("v%0d_ready_commit", i), 32'(bus.byte_ready), 0);
      chk($sformatf("v%0d_kv_early", i), 32'(bus.keycode_valid), 0);
      @(negedge Clk);
      chk($sformatf("v%0d_keycode", i), 32'(bus.keycode), 32'(vecs[i].k));
      chk($sformatf("v%0d_kv", i), 32'(bus.keycode_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_err", i), 32'(bus.report_error), 32'(vecs[i].e));
      chk($sformatf("v%0d_ready_after", i), 32'(bus.byte_ready), 1);
      @(negedge Clk);
      chk($sformatf("v%0d_kv_drop", i), 32'(bus.keycode_valid), 0);
      chk($sformatf("v%0d_err_drop", i), 32'(bus.report_error), 0);
    end
    kv_cnt = 0;
    err_cnt = 0;
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    repeat (2) @(negedge Clk);
    chk("nosof_err_cnt", err_cnt, 3);
    chk("nosof_kv_cnt", kv_cnt, 0);
    chk("nosof_keycode", 32'(bus.keycode), 32'h0000);
    send_bytes(64'h0000_1A16_0000_0000, 4, 1'b0);
    send_bytes(64'h0000_1600_0000_0000, 8, 1'b0);
    repeat (2) @(negedge Clk);
    chk("restart_err_cnt", err_cnt, 4);
    chk("restart_kv_cnt", kv_cnt, 1);
    chk("restart_keycode", 32'(bus.keycode), 32'h1600);
    kv_cnt = 0;
    err_cnt = 0;
    send_bytes(64'h0000_1A16_0000_0000, 4, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("midrst_keycode", 32'(bus.keycode), 32'h0000);
    chk("midrst_kv_cnt", kv_cnt, 0);
    chk("midrst_ready", 32'(bus.byte_ready), 1);
    send_bytes(64'h0000_2B00_0000_0000, 8, 1'b1);
    repeat (2) @(negedge Clk);
    chk("postrst_keycode", 32'(bus.keycode), 32'h2B00);
    chk("postrst_kv_cnt", kv_cnt, 1);
    chk("postrst_err_cnt", err_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keycode_report_packer.md
Name: keycode_report_packer

Overview:
- Assembles the 16-bit two-key keycode word consumed by the player keycode splitter.
- Input is a USB HID boot-keyboard report, delivered one byte at a time from the USB/NIOS host interface over a valid/ready handshake.
- Extracts up to two pressed-key codes from the report.
- Commits them as one atomic word with a one-cycle update strobe; rollover and framing errors are rejected.

Parameters:
REPORT_BYTES, 8, bytes per report; byte 0 = modifiers, byte 1 = reserved, bytes 2..REPORT_BYTES-1 = key slots
ROLLOVER_CODE, 8'h01, HID ErrorRollOver code; any report containing it is discarded

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
byte_valid  input  1  byte_data is valid this cycle
byte_ready  output  1  block accepts a byte this cycle
byte_data  input  8  report byte
byte_sof  input  1  marks the first byte (byte 0) of a report; qualified by byte_valid
keycode  output  16  [15:8] = first nonzero key code, [7:0] = second; 8'h00 = no key
keycode_valid  output  1  one-cycle pulse when keycode is updated
report_error  output  1  one-cycle pulse on a framing or rollover error

Behaviour:
- Clock and reset: single clock domain, Clk. Reset is synchronous and active-high, applied only on the rising edge of Clk.
- Reset values: keycode = 16'h0000, keycode_valid = 0, report_error = 0, state = IDLE, byte index = 0, both slots = 8'h00, rollover flag = 0.
- Reset mid-report: the partial report is discarded; keycode returns to 16'h0000 with no keycode_valid pulse.
- Accept rule: a byte transfers on a rising edge where byte_valid && byte_ready. byte_valid may drop between bytes; gaps of any length are legal.
- byte_ready is decoded from state: 1 in IDLE and COLLECT, 0 in COMMIT.
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - Accepted byte with byte_sof=1: index <= 1, slots cleared, rollover flag cleared, go to COLLECT. Byte 0 content is ignored.
  - Accepted byte with byte_sof=0: byte dropped, report_error pulse, stay in IDLE.
- COLLECT:
  - Accepted byte with byte_sof=1: restart. report_error pulse, index <= 1, slots and flag cleared, stay in COLLECT.
  - Accepted byte with byte_sof=0 at index i: index <= i+1.
  - For 2 <= i <= REPORT_BYTES-1 with a nonzero byte:
    - Byte == ROLLOVER_CODE: set the rollover flag.
    - Else, slot0 empty: slot0 <= byte.
    - Else, slot1 empty and byte != slot0: slot1 <= byte.
    - Otherwise: ignore the byte (third and later keys, duplicates).
  - Zero bytes never fill a slot. Byte 1 is always ignored.
  - When index REPORT_BYTES-1 is accepted, go to COMMIT.
- COMMIT (exactly one cycle):
  - Rollover flag set: keycode is held unchanged and report_error pulses.
  - Otherwise: keycode <= {slot0, slot1} and keycode_valid pulses, even if the value is unchanged or all zero (key release).
  - Next state is IDLE.
- Latency: the last byte is accepted on edge N. keycode and keycode_valid update on edge N+1. A new report's byte_sof may be accepted from edge N+2.
- keycode_valid and report_error are registered and are never both high in the same cycle.
- Single-key report: slot1 = 8'h00, giving keycode = {key, 8'h00}.
- Index counter width: $clog2(REPORT_BYTES). No wrap is possible, because reaching REPORT_BYTES-1 always exits COLLECT.

Test Plan:
1. Assert Reset for 2 cycles, then release -> keycode=16'h0000, keycode_valid=0, report_error=0, byte_ready=1.
2. Report 00 00 1A 52 00 00 00 00, back-to-back with sof on byte 0 -> keycode=16'h1A52 one cycle after the last byte, keycode_valid high exactly 1 cycle, byte_ready low exactly 1 cycle.
3. Report 02 00 00 04 07 2C 00 00, with random byte_valid gaps -> keycode=16'h0407; 2C ignored; modifier byte ignored.
4. After step 2, send 00 00 01 01 01 01 01 01 -> report_error pulse, keycode stays 16'h1A52, no keycode_valid.
5. Framing:
   - 3 bytes sent without sof -> 3 report_error pulses, nothing committed.
   - Then 4 bytes of a report, followed by a new sof report 00 00 16 00 00 00 00 00 -> 1 report_error pulse at the restart, then keycode=16'h1600.
6. Release and reset:
   - All-zero report -> keycode=16'h0000 with a keycode_valid pulse.
   - Then Reset asserted after byte 3 of report 00 00 1A 16 .. -> keycode=16'h0000, no keycode_valid; the next full report commits normally.
